sliding_window_3x3: RTL and testbench

SLIDING_WINDOW_3X3 -- requirements
Module: sliding_window_3x3

---
 rtl/filter_pkg.sv | 9 +
 rtl/line_buffer.sv | 23 ++
 rtl/sliding_window_3x3.sv | 123 ++++++++++++
 tb/tb_sliding_window_3x3.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - pixel and window constants shared by the 3x3 window block and the filter pipeline
package filter_pkg;
  localparam int PIX_W     = 8;
  localparam int WIN_N     = 9;
  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;

  typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one image line of pixel storage with one read and one write port
module line_buffer
  import filter_pkg::*;
#(
  parameter int  DEPTH = IMG_W_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);
  // Combinational read sees the old word during a same-address write (read-before-write).
  pix_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sliding_window_3x3.sv
// rtl/sliding_window_3x3.sv - raster-order 3x3 pixel window generator
// Optional WINDOW_SOF_EN adds in_sof, which restarts the frame at the flagged pixel.
module sliding_window_3x3
  import filter_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef WINDOW_SOF_EN
  input  logic             in_sof,
`endif
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             act,
  output logic [PIX_W-1:0] sw_pixel_1,
  output logic [PIX_W-1:0] sw_pixel_2,
  output logic [PIX_W-1:0] sw_pixel_3,
  output logic [PIX_W-1:0] sw_pixel_4,
  output logic [PIX_W-1:0] sw_pixel_5,
  output logic [PIX_W-1:0] sw_pixel_6,
  output logic [PIX_W-1:0] sw_pixel_7,
  output logic [PIX_W-1:0] sw_pixel_8,
  output logic [PIX_W-1:0] sw_pixel_9,
  output logic             frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;
  pix_t          win_q [WIN_N];
  pix_t          win_d [WIN_N];
  logic          act_q, act_d;
  logic          done_q, done_d;
  pix_t          lb0_rd, lb1_rd;
  logic          sof;

`ifdef WINDOW_SOF_EN
  assign sof = in_sof;
`else
  assign sof = 1'b0;
`endif

  // Position of the pixel being accepted; a start-of-frame marker forces it to (0,0).
  assign pos_col = sof ? '0 : col_q;
  assign pos_row = sof ? '0 : row_q;

  line_buffer #(.DEPTH(IMG_W)) u_lb0 (
    .clk   (clk),
    .wr_en (in_valid),
    .waddr (pos_col),
    .wdata (in_pixel),
    .raddr (pos_col),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk   (clk),
    .wr_en (in_valid),
    .waddr (pos_col),
    .wdata (lb0_rd),
    .raddr (pos_col),
    .rdata (lb1_rd)
  );

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    act_d  = 1'b0;
    done_d = 1'b0;
    for (int i = 0; i < WIN_N; i++) win_d[i] = win_q[i];
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = in_pixel;
      // Both line buffers only hold current-frame data once row >= 2, so stale
      // contents never reach a qualified window.
      act_d  = (pos_row >= RW'(2)) && (pos_col >= CW'(2));
      done_d = (pos_row == RW'(IMG_H-1)) && (pos_col == CW'(IMG_W-1));
      if (pos_col == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (pos_row == RW'(IMG_H-1)) ? '0 : pos_row + RW'(1);
      end else begin
        col_d = pos_col + CW'(1);
        row_d = pos_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q  <= '0;
      row_q  <= '0;
      act_q  <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < WIN_N; i++) win_q[i] <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      act_q  <= act_d;
      done_q <= done_d;
      for (int i = 0; i < WIN_N; i++) win_q[i] <= win_d[i];
    end
  end

  assign act        = act_q;
  assign frame_done = done_q;
  assign sw_pixel_1 = win_q[0];
  assign sw_pixel_2 = win_q[1];
  assign sw_pixel_3 = win_q[2];
  assign sw_pixel_4 = win_q[3];
  assign sw_pixel_5 = win_q[4];
  assign sw_pixel_6 = win_q[5];
  assign sw_pixel_7 = win_q[6];
  assign sw_pixel_8 = win_q[7];
  assign sw_pixel_9 = win_q[8];
endmodule

// File: tb/tb_sliding_window_3x3.sv
// tb/tb_sliding_window_3x3.sv - self-checking bench for sliding_window_3x3 against an image-array model
module tb_sliding_window_3x3;
  localparam int W = 8;
  localparam int H = 8;
`ifdef WINDOW_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_pixel = 8'd0;
`ifdef WINDOW_SOF_EN
  logic       in_sof = 1'b0;
`endif
  logic       act, frame_done;
  logic [7:0] sw_p [9];

  int n_cmp = 0;
  int n_err = 0;

  // Model: the current frame as a 2D image plus the raster position of the next pixel.
  logic [7:0] img [H][W];
  logic [7:0] exp_win [9];
  bit         win_known;
  int         mr, mc;
  int         n_act, n_done, first_act;

  always #5 clk = ~clk;

  sliding_window_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef WINDOW_SOF_EN
    .in_sof     (in_sof),
`endif
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .act        (act),
    .sw_pixel_1 (sw_p[0]),
    .sw_pixel_2 (sw_p[1]),
    .sw_pixel_3 (sw_p[2]),
    .sw_pixel_4 (sw_p[3]),
    .sw_pixel_5 (sw_p[4]),
    .sw_pixel_6 (sw_p[5]),
    .sw_pixel_7 (sw_p[6]),
    .sw_pixel_8 (sw_p[7]),
    .sw_pixel_9 (sw_p[8]),
    .frame_done (frame_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mr = 0;
    mc = 0;
    win_known = 1'b1;
    for (int k = 0; k < 9; k++) exp_win[k] = 8'd0;
  endtask

  task automatic seg_reset();
    n_act = 0;
    n_done = 0;
    first_act = -1;
  endtask

  task automatic check_win(input string what);
    for (int k = 0; k < 9; k++)
      check_eq($sformatf("%s_sw%0d", what, k + 1), sw_p[k], exp_win[k]);
  endtask

  task automatic step(input bit v, input logic [7:0] p, input bit s);
    bit ea, ed;
    in_valid = v;
    in_pixel = p;
`ifdef WINDOW_SOF_EN
    in_sof = s;
`endif
    @(posedge clk);
    #1;
    ea = 1'b0;
    ed = 1'b0;
    if (v) begin
      if (s && SOF_EN) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = p;
      ea = (mr >= 2) && (mc >= 2);
      ed = (mr == H - 1) && (mc == W - 1);
      if (ea) begin
        for (int k = 0; k < 9; k++) exp_win[k] = img[mr - 2 + k / 3][mc - 2 + k % 3];
        if (first_act < 0) first_act = mr * W + mc;
      end
      win_known = ea;
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end
    end
    check_eq("act", act, ea);
    check_eq("frame_done", frame_done, ed);
    if (win_known) check_win(v ? "win" : "hold");
    if (ea) n_act++;
    if (ed) n_done++;
  endtask

  task automatic pattern_frame(input int gap_after);
    for (int p = 0; p < W * H; p++) begin
      step(1'b1, 8'(p), 1'b0);
      if (p == gap_after) repeat (5) step(1'b0, 8'hA5, 1'b0);
    end
  endtask

  task automatic check_frame(input string what);
    check_eq({what, "_act_count"}, n_act, (W - 2) * (H - 2));
    check_eq({what, "_done_count"}, n_done, 1);
    check_eq({what, "_first_act_pix"}, first_act, 2 * W + 2);
  endtask

  initial begin
    model_reset();
    seg_reset();
    repeat (3) step(1'b0, 8'd0, 1'b0);
    rst = 1'b1;

    pattern_frame(20);
    check_frame("frame_a");
    seg_reset();
    pattern_frame(-1);
    check_frame("frame_b");
    seg_reset();

    for (int p = 0; p < W * H; p++) begin
      while ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), 1'b0);
      step(1'b1, 8'($urandom), 1'b0);
    end
    check_frame("frame_rand");
    seg_reset();

    for (int p = 0; p <= 30; p++) step(1'b1, 8'(p), 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_act", act, 1'b0);
    check_eq("rst_done", frame_done, 1'b0);
    check_win("rst");
    repeat (2) step(1'b0, 8'd0, 1'b0);
    #3;
    rst = 1'b1;
    seg_reset();
    pattern_frame(-1);
    check_frame("after_rst");
    seg_reset();

    if (SOF_EN) begin
      for (int p = 0; p < 40; p++) step(1'b1, 8'(p), 1'b0);
      seg_reset();
      step(1'b1, 8'($urandom), 1'b1);
      for (int p = 0; p < 30; p++) step(1'b1, 8'($urandom), 1'b0);
      check_eq("sof_first_act_pix", first_act, 2 * W + 2);
      check_eq("sof_done_count", n_done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
